arb_rr_8x3: RTL and testbench
=============================

ARB_RR_8X3 -- requirements
Module: arb_rr_8x3

Interface
REQ-001 Parameter: N_REQ, 8, number of requesters; fixed at 8, other values unsupported.
REQ-002 Parameter: TIMEOUT_CYC, 16, maximum grant hold in cycles; used only with ARB_TIMEOUT_EN; legal range 2..255.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: req  input  8  request vector; bit i high = requester i wants the resource.
REQ-006 Port: done  input  1  current grantee releases the resource; ignored when grant_valid is low.
REQ-007 Port: grant  output  8  one-hot grant vector; all zero when no grant is active.
REQ-008 Port: grant_idx  output  3  binary index of the granted requester, 8-to-3 encoded from grant; 0 when no grant is active.
REQ-009 Port: grant_valid  output  1  high while a grant is held.
REQ-010 Port: timeout  output  1  one-cycle pulse on a forced release; tied 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-011 The FSM SHALL have two states, IDLE and GRANT, and SHALL have no other reachable state.
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with all outputs zero.
REQ-013 In IDLE with req != 0, the block SHALL select the first set bit scanning upward from the pointer ptr and wrapping 7->0; it SHALL register that grant and enter GRANT on the same edge, so grant_valid rises one cycle after req is first sampled high.
REQ-014 grant, grant_idx and grant_valid SHALL be registered outputs, with grant always consistent with grant_idx.
REQ-015 In GRANT, the grant SHALL hold unchanged regardless of other req bits until a release event occurs.
REQ-016 Release events:
- done high, or
- req[grant_idx] low, or
- timeout (see REQ-024).
REQ-017 On a release event at edge k, grant SHALL be all zero after edge k, the state SHALL return to IDLE, and ptr SHALL be set to (grant_idx+1) mod 8, with 7 wrapping to 0.
REQ-018 Every grant SHALL be followed by at least one IDLE cycle; no back-to-back grants.
REQ-019 Fairness: with all 8 requests held continuously, each requester SHALL be granted exactly once in every 8 consecutive grants.
REQ-020 When done and a req drop occur in the same cycle, the block SHALL perform a single release and a single ptr update.
REQ-021 A done pulse while in IDLE SHALL have no effect.

Reset
REQ-022 While rst_n is low, the block SHALL force: state = IDLE, ptr = 0, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0, hold counter = 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately, asynchronously; after rst_n deasserts, arbitration SHALL restart from ptr = 0 on the first clock edge.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined:
- a hold counter SHALL clear on grant entry and increment on each GRANT cycle;
- when it reaches TIMEOUT_CYC-1 without another release event, the block SHALL perform a forced release per REQ-017 and pulse timeout for exactly one cycle, aligned with grant dropping.
REQ-025 With ARB_TIMEOUT_EN undefined:
- the block SHALL contain no hold counter;
- grants SHALL be held indefinitely until done or a req drop;
- timeout SHALL be constant 0.

Structure
REQ-026 Shared package arb_pkg SHALL hold N_REQ, IDX_W (3), the default TIMEOUT_CYC, and the state enum (IDLE, GRANT).
REQ-027 The round-robin selection SHALL be a combinational sub-module rr_pick8 with inputs req[7:0] and ptr[2:0] and outputs onehot[7:0], idx[2:0] and any[1]; arb_rr_8x3 SHALL instantiate it exactly once.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset, then req = 8'b0000_0001 -> grant = 8'h01, grant_idx = 0, grant_valid = 1 one cycle later; done -> grant = 0 next cycle, ptr = 1.
- req = 8'hFF held, done pulsed once per grant -> grant_idx sequence 0,1,2,...,7,0 with one IDLE cycle between each grant.
- ptr = 7 and req = 8'b1000_0001 -> grant_idx = 7; after release -> grant_idx = 0, confirming the 7->0 wrap.
- Holding grant_idx = 3, then req[5] raised -> grant stays 8'h08; drop req[3] -> grant = 0 next cycle, then grant_idx = 5.
- rst_n pulled low mid-grant (grant = 8'h10) -> grant = 0 immediately without a clock edge; after release, req = 8'h30 -> grant_idx = 4.
- ARB_TIMEOUT_EN with TIMEOUT_CYC = 16, req = 8'h04 held, done never asserted -> grant drops after 16 GRANT cycles with a single-cycle timeout pulse, then grant_idx = 2 again after one IDLE cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state encoding for the 8-way round-robin arbiter
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int DEF_TIMEOUT_CYC = 16;
    typedef enum logic {IDLE, GRANT} state_e;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker, first set req bit scanning up from ptr with 7->0 wrap
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [IDX_W-1:0] j;
    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        onehot = '0;
        idx = '0;
        j = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = ptr + IDX_W'(k);
            if (req[j]) begin
                onehot = N_REQ'(1) << j;
                idx = j;
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/arb_rr_8x3.sv
// arb_rr_8x3: 8-requester round-robin arbiter with registered one-hot grant; optional hold timeout under ARB_TIMEOUT_EN
module arb_rr_8x3 #(
    parameter int N_REQ = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_idx,
    output logic             grant_valid,
    output logic             timeout
);
    import arb_pkg::*;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
    logic [N_REQ-1:0] grant_q, grant_d, pick_onehot;
    logic             pick_any, rel, forced;
    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    assign forced = cnt_q == 8'(TIMEOUT_CYC - 1);
    // Counter sits at zero in IDLE so it is already cleared on grant entry.
    always_comb begin
        cnt_d = (state_q == GRANT) ? cnt_q + 8'd1 : 8'd0;
        timeout_d = (state_q == GRANT) && forced && !done && req[idx_q];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign forced = 1'b0;
    assign timeout = 1'b0;
`endif
    assign rel = done || !req[idx_q] || forced;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        grant_d = grant_q;
        idx_d = idx_q;
        if (state_q == IDLE && pick_any) begin
            state_d = GRANT;
            grant_d = pick_onehot;
            idx_d = pick_idx;
        end else if (state_q == GRANT && rel) begin
            state_d = IDLE;
            grant_d = '0;
            idx_d = '0;
            ptr_d = idx_q + IDX_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            grant_q <= '0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            grant_q <= grant_d;
            idx_q <= idx_d;
        end
    end
    assign grant = grant_q;
    assign grant_idx = idx_q;
    assign grant_valid = state_q == GRANT;
endmodule

// File: tb/tb_arb_rr_8x3.sv
// tb_arb_rr_8x3: directed self-checking bench for arb_rr_8x3; timeout scenario active when ARB_TIMEOUT_EN is defined
module tb_arb_rr_8x3;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;

    arb_rr_8x3 #(.N_REQ(8), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_idx"}, {5'd0, grant_idx}, {5'd0, i});
        chk({tag, "_valid"}, {7'd0, grant_valid}, {7'd0, v});
        chk({tag, "_timeout"}, {7'd0, timeout}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 8'h00;
        done = 1'b0;
        tick();
        tick();
        chk_grant("reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester, then done; ptr=1 shown by picking bit 1 over bit 0
        req = 8'h01;
        tick();
        chk_grant("s1_grant", 8'h01, 3'd0, 1'b1);
        done = 1'b1;
        tick();
        chk_grant("s1_release", 8'h00, 3'd0, 1'b0);
        done = 1'b0;
        req = 8'h03;
        tick();
        chk_grant("s1_ptr1", 8'h02, 3'd1, 1'b1);
        req = 8'h00;
        done = 1'b1;
        tick();
        chk_grant("s1_drop", 8'h00, 3'd0, 1'b0);
        tick();
        chk_grant("idle_done", 8'h00, 3'd0, 1'b0);
        done = 1'b0;

        // restart from ptr=0 and rotate through all requesters
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_grant($sformatf("rr%0d", i), 8'h01 << (i % 8), 3'(i % 8), 1'b1);
            done = 1'b1;
            tick();
            chk_grant($sformatf("rr%0d_gap", i), 8'h00, 3'd0, 1'b0);
            done = 1'b0;
        end

        // ptr=1: grant 6, release by req drop -> ptr=7, then 7->0 wrap
        req = 8'h40;
        tick();
        chk_grant("w_g6", 8'h40, 3'd6, 1'b1);
        req = 8'h00;
        tick();
        chk_grant("w_rel6", 8'h00, 3'd0, 1'b0);
        req = 8'h81;
        tick();
        chk_grant("w_g7", 8'h80, 3'd7, 1'b1);
        done = 1'b1;
        tick();
        chk_grant("w_rel7", 8'h00, 3'd0, 1'b0);
        done = 1'b0;
        tick();
        chk_grant("w_g0", 8'h01, 3'd0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;

        // ptr=1: hold grant 3 while req[5] rises
        req = 8'h08;
        tick();
        chk_grant("h_g3", 8'h08, 3'd3, 1'b1);
        req = 8'h28;
        tick();
        chk_grant("h_hold1", 8'h08, 3'd3, 1'b1);
        tick();
        chk_grant("h_hold2", 8'h08, 3'd3, 1'b1);
        req = 8'h20;
        tick();
        chk_grant("h_rel3", 8'h00, 3'd0, 1'b0);
        tick();
        chk_grant("h_g5", 8'h20, 3'd5, 1'b1);

        // done and req drop together: single ptr update to 6
        done = 1'b1;
        req = 8'h00;
        tick();
        chk_grant("both_rel", 8'h00, 3'd0, 1'b0);
        done = 1'b0;
        req = 8'hC0;
        tick();
        chk_grant("both_g6", 8'h40, 3'd6, 1'b1);
        req = 8'h00;
        tick();

        // asynchronous reset mid-grant
        req = 8'h10;
        tick();
        chk_grant("ar_g4", 8'h10, 3'd4, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_grant("ar_async", 8'h00, 3'd0, 1'b0);
        req = 8'h30;
        tick();
        chk_grant("ar_hold", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_grant("ar_g4b", 8'h10, 3'd4, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;

        // long hold of requester 2 with done never asserted
        req = 8'h04;
        tick();
        chk_grant("to_g2", 8'h04, 3'd2, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            tick();
            chk_grant($sformatf("to_hold%0d", c), 8'h04, 3'd2, 1'b1);
        end
        tick();
        chk("to_drop_grant", grant, 8'h00);
        chk("to_drop_valid", {7'd0, grant_valid}, 8'd0);
        chk("to_pulse", {7'd0, timeout}, 8'd1);
        tick();
        chk_grant("to_regrant", 8'h04, 3'd2, 1'b1);
`else
        for (int c = 0; c < 40; c++) tick();
        chk_grant("to_none", 8'h04, 3'd2, 1'b1);
        done = 1'b1;
        tick();
        chk_grant("to_done", 8'h00, 3'd0, 1'b0);
        done = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
